// File: rtl/fnd_scan_mux.sv
// rtl/fnd_scan_mux.sv - time-multiplexed common-anode FND scan driver
// Adds a slot prescaler, dead time, PWM brightness, leading-zero blanking and frame snapshots.
module fnd_scan_mux #(
  parameter int DIGITS         = 4,
  parameter int PRESCALE       = 1000,
  parameter int DEAD           = 8,
  parameter bit SEL_ACTIVE_LOW = 1'b1,
  parameter int CW             = $clog2(PRESCALE),
  parameter int IW             = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [3:0]            bright,
  output logic [3:0]            mux_out,
  output logic                  mux_dp,
  output logic [DIGITS-1:0]     mux_sel,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_start
);

  localparam logic [DIGITS-1:0] SEL_IDLE = {DIGITS{SEL_ACTIVE_LOW}};

  logic                 run_q, run_d;
  logic [CW-1:0]        slot_q, slot_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [3:0]           pwm_q, pwm_d;
  logic [4*DIGITS-1:0]  snap_dig_q, snap_dig_d;
  logic [DIGITS-1:0]    snap_dp_q, snap_dp_d;
  logic                 snap_blz_q, snap_blz_d;

  logic [3:0]           mux_out_q, mux_out_d;
  logic                 mux_dp_q, mux_dp_d;
  logic [DIGITS-1:0]    mux_sel_q, mux_sel_d;
  logic                 frame_q, frame_d;

  logic [DIGITS-1:0]    blank;
  logic                 zero_run;
  logic                 past_dead;
  logic                 pwm_on;
  logic                 lit;
  logic [DIGITS-1:0]    onehot;

  // Scan counters: the first enabled edge restarts at slot 0 / cycle 0.
  always_comb begin
    run_d  = run_q;
    slot_d = slot_q;
    idx_d  = idx_q;
    pwm_d  = pwm_q;
    if (!en) begin
      run_d  = 1'b0;
      slot_d = '0;
      idx_d  = '0;
      pwm_d  = '0;
    end else if (!run_q) begin
      run_d  = 1'b1;
      slot_d = '0;
      idx_d  = '0;
      pwm_d  = '0;
    end else if (slot_q == CW'(PRESCALE - 1)) begin
      slot_d = '0;
      pwm_d  = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      slot_d = slot_q + 1'b1;
      pwm_d  = pwm_q + 4'd1;
    end
  end

  assign frame_d = en && (slot_d == '0) && (idx_d == '0);

  // Snapshot is taken on the same edge that presents slot 0 so a frame never tears.
  always_comb begin
    snap_dig_d = snap_dig_q;
    snap_dp_d  = snap_dp_q;
    snap_blz_d = snap_blz_q;
    if (frame_d) begin
      snap_dig_d = digits_in;
      snap_dp_d  = dp_in;
      snap_blz_d = blank_lz;
    end
  end

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (snap_dig_d[4*k +: 4] == 4'd0);
      blank[k] = snap_blz_d && (k != 0) && zero_run;
    end
  end

  assign past_dead = (DEAD == 0) || (slot_d >= CW'(DEAD));
  assign pwm_on    = (bright == 4'd15) || (pwm_d < bright);
  assign lit       = en && past_dead && !blank[idx_d] && pwm_on;
  assign onehot    = lit ? (DIGITS'(1) << idx_d) : '0;

  always_comb begin
    mux_sel_d = SEL_ACTIVE_LOW ? ~onehot : onehot;
    mux_out_d = en ? snap_dig_d[{idx_d, 2'b00} +: 4] : 4'd0;
    mux_dp_d  = en && snap_dp_d[idx_d] && !blank[idx_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q      <= 1'b0;
      slot_q     <= '0;
      idx_q      <= '0;
      pwm_q      <= '0;
      snap_dig_q <= '0;
      snap_dp_q  <= '0;
      snap_blz_q <= 1'b0;
      mux_out_q  <= '0;
      mux_dp_q   <= 1'b0;
      mux_sel_q  <= SEL_IDLE;
      frame_q    <= 1'b0;
    end else begin
      run_q      <= run_d;
      slot_q     <= slot_d;
      idx_q      <= idx_d;
      pwm_q      <= pwm_d;
      snap_dig_q <= snap_dig_d;
      snap_dp_q  <= snap_dp_d;
      snap_blz_q <= snap_blz_d;
      mux_out_q  <= mux_out_d;
      mux_dp_q   <= mux_dp_d;
      mux_sel_q  <= mux_sel_d;
      frame_q    <= frame_d;
    end
  end

  assign mux_out     = mux_out_q;
  assign mux_dp      = mux_dp_q;
  assign mux_sel     = mux_sel_q;
  assign digit_idx   = idx_q;
  assign frame_start = frame_q;

endmodule

// File: doc/fnd_scan_mux.md
# fnd_scan_mux

Parametrised time-multiplexed driver for common-anode multi-digit FND displays. It scans DIGITS hex nibbles onto one shared segment bus, one digit at a time, from the stopwatch/counter datapath. Over a fixed 4-digit, every-clock scan it adds:
- a programmable slot prescaler;
- per-slot dead time for anti-ghosting;
- 16-level brightness PWM;
- leading-zero blanking;
- decimal points;
- tear-free frame snapshots.

## Interface
- DIGITS, 4, number of digits scanned (2..8)
- PRESCALE, 1000, clk cycles per digit slot (>= DEAD+2)
- DEAD, 8, cycles at start of each slot with all selects inactive (0 allowed)
- SEL_ACTIVE_LOW, 1, 1: active select = 0, inactive = 1; 0: inverted

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  scan enable
- digits_in  in  4*DIGITS  digit k at bits [4k+3:4k]; digit 0 = least significant
- dp_in  in  DIGITS  decimal point request per digit
- blank_lz  in  1  enable leading-zero blanking
- bright  in  4  brightness, 0 = dark, 15 = full on
- mux_out  out  4  nibble of the current digit (to segment decoder)
- mux_dp  out  1  decimal point of the current digit
- mux_sel  out  DIGITS  digit select, one-hot active per SEL_ACTIVE_LOW
- digit_idx  out  clog2(DIGITS)  index of the current slot
- frame_start  out  1  one-cycle pulse on first cycle of slot 0

## Operation
- Counters:
  - slot_cnt: 0..PRESCALE-1.
  - idx: 0..DIGITS-1, advances when slot_cnt wraps; wraps DIGITS-1 -> 0.
  - pwm_cnt: 4-bit, cleared at every slot start, then increments and wraps 15 -> 0.
- Snapshot: digits_in, dp_in and blank_lz are captured into internal registers on entry to slot 0 only. Input changes mid-frame are invisible until the next frame.
- Leading-zero blanking (snapshot values): digit k (k >= 1) is blanked when blank_lz = 1 and every digit k..DIGITS-1 equals 0. Digit 0 is never blanked. A blanked digit keeps its select inactive for the whole slot; its dp is ignored.
- Select for digit k in slot k is active only when all of the following hold:
  - slot_cnt >= DEAD;
  - the digit is not blanked;
  - (pwm_cnt < bright) or (bright == 15).
- In all other cases every select is inactive.
- mux_out and mux_dp equal the snapshot nibble and dp of digit idx for the whole slot, including dead time.
- en = 0:
  - Next cycle all selects go inactive, mux_out and mux_dp go to 0, and frame_start goes to 0.
  - idx, slot_cnt and pwm_cnt are held at 0.
- en rising: the scan restarts at slot 0, cycle 0, takes a new snapshot and begins with dead time.
- Reset values:
  - mux_sel all inactive (all ones when SEL_ACTIVE_LOW = 1);
  - mux_out = 0, mux_dp = 0, digit_idx = 0, frame_start = 0;
  - all counters and snapshot registers = 0.

## Timing
- All outputs are registered and change only on the rising edge of clk. The design has no combinational path from inputs to outputs.
- Frame length: DIGITS*PRESCALE cycles. Digit refresh rate: f_clk / (DIGITS*PRESCALE).
- First edge with en = 1 after reset release (or after en rises): outputs present slot 0, cycle 0. frame_start = 1 and the snapshot is taken on that same edge.
- Snapshot latency: a digits_in change becomes visible at the first cycle of the next slot 0, which is at most DIGITS*PRESCALE cycles later.
- Select on-cycles per slot:
  - bright = 15: PRESCALE-DEAD.
  - bright = b < 15: count of cycles in [DEAD, PRESCALE-1] whose pwm_cnt < b.
- Within the same edge, no two selects are ever active together. Between slots, DEAD >= 1 guarantees at least DEAD all-inactive cycles.
- Asynchronous rst mid-slot forces the reset values immediately. Scanning resumes at slot 0 on the first edge after deassertion.

## Test plan
- DIGITS = 4, PRESCALE = 10, DEAD = 2, bright = 15, digits_in = 16'h1234, en = 1:
  - slot k shows mux_out = 4, 3, 2, 1 for idx 0..3;
  - mux_sel = 1110 / 1101 / 1011 / 0111 in cycles 2..9 of each slot, 1111 in cycles 0..1;
  - frame_start pulses every 40 cycles.
- Change digits_in from 16'h1234 to 16'h5678 during slot 1: slots 1..3 still show 3, 2, 1; the next frame shows 8, 7, 6, 5.
- blank_lz = 1, digits_in = 16'h0050, dp_in = 4'b1000:
  - digits 3 and 2 are blanked, so their selects are inactive for the whole slot and the dp on digit 3 is suppressed;
  - digit 1 shows 5 and digit 0 shows 0, both active.
- bright = 4, PRESCALE = 34, DEAD = 2: each slot has exactly 8 active select cycles (pwm_cnt 0..3 in each of the two 16-cycle PWM periods). bright = 0 gives 0 active cycles.
- en dropped mid-slot 2:
  - next cycle mux_sel = 1111, mux_out = 0, and the counters are at 0;
  - re-raising en gives frame_start = 1, idx = 0, and 2 dead cycles.
- rst asserted asynchronously mid-slot 3: all outputs reach reset values without waiting for a clk edge. After release, scanning restarts at idx = 0 with frame_start = 1.
